// File: rtl/strobe_write_arbiter.sv
// Latches single-cycle register-write strobes from NUM_REQ sources and serialises them round-robin onto one write port.
// Latency: strobe in cycle T -> pending at T+1 -> wr_en at T+2 when idle; one write per 2+GAP_CYCLES cycles.
// Backpressure: wr_en/addr/data/grant hold until wr_ready; a strobe on a still-pending source is dropped and flagged in overrun.
module strobe_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_strobe,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        pending,
  output logic [NUM_REQ-1:0]        overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    sel_q, sel_d;
  logic [3:0]          gap_q, gap_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  logic [NUM_REQ-1:0]  ovr_q, ovr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0]   word_addr_q [NUM_REQ];
  logic [ADDR_W-1:0]   word_addr_d [NUM_REQ];
  logic [DATA_W-1:0]   word_data_q [NUM_REQ];
  logic [DATA_W-1:0]   word_data_d [NUM_REQ];
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [NUM_REQ-1:0]  retire;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;

  assign retire = (state_q == S_ISSUE && wr_ready) ? grant_q : '0;

  // Scan downward so the last hit (closest to the pointer) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend_q[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gap_d       = gap_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    grant_d     = grant_q;
    word_addr_d = word_addr_q;
    word_data_d = word_data_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (overrun_clr) ovr_d = '0;

    // A source being retired this cycle may reload immediately without overrun.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (retire[i]) pend_d[i] = 1'b0;
      if (req_strobe[i]) begin
        if (!pend_q[i] || retire[i]) begin
          pend_d[i]      = 1'b1;
          word_addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
          word_data_d[i] = req_data[i*DATA_W +: DATA_W];
        end else begin
          ovr_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d           = S_ISSUE;
          sel_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          wr_en_d           = 1'b1;
          wr_addr_d         = word_addr_q[pick_idx];
          wr_data_d         = word_data_q[pick_idx];
        end
      end
      S_ISSUE: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
          grant_d = '0;
          ptr_d   = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = 4'(GAP_CYCLES - 1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gap_q     <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      grant_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        word_addr_q[i] <= '0;
        word_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gap_q       <= gap_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      grant_q     <= grant_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      word_addr_q <= word_addr_d;
      word_data_q <= word_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign grant   = grant_q;
  assign pending = pend_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != S_IDLE) || (|pend_q);

endmodule

// File: tb/tb_strobe_write_arbiter.sv
// Bench for strobe_write_arbiter: directed strobe sequences; expected writes queued at issue, checked by a write-port monitor.
// Latency: expected cycles are hand-computed relative to the strobe cycle.
// Backpressure: wr_ready is driven directly to exercise stalls and same-cycle retire/reload.
module tb_strobe_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_strobe = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  pending;
  logic [3:0]  overrun;
  logic        overrun_clr = 1'b0;
  logic        busy;

  typedef struct {
    logic [3:0] g;
    logic [5:0] a;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   cyc   = 0;

  strobe_write_arbiter #(
    .NUM_REQ(4), .ADDR_W(6), .DATA_W(8), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_strobe(req_strobe), .req_addr(req_addr), .req_data(req_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .grant(grant), .pending(pending), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_write: got grant=%b addr=%0h data=%0h, expected no write", grant, wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_grant", 32'(grant), 32'(e.g));
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [7:0] d);
    req_strobe[i]      = 1'b1;
    req_addr[i*6 +: 6] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic push(input int i, input logic [5:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.g    = '0;
    e.g[i] = 1'b1;
    e.a    = a;
    e.d    = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_strobe  = '0;
    overrun_clr = 1'b0;
    wr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int lim);
    for (int k = 0; k < lim && sb.size() != 0; k++) tick();
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", sb.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_accept(output int g, output bit ok);
    ok = 1'b0;
    g  = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (wr_en && wr_ready) ok = 1'b1;
    end
    for (int k = 0; k < 4; k++) if (grant[k]) g = k;
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout: got no write within 50 cycles, expected one");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int g;
    bit ok;

    // Single write with latency check.
    do_reset();
    wr_ready = 1'b1;
    t = cyc;
    set_req(2, 6'h20, 8'h0E);
    push(2, 6'h20, 8'h0E, t + 2);
    tick();
    req_strobe = '0;
    chk("t1_pending_t1", 32'(pending), 32'b0100);
    chk("t1_wr_en_t1", 32'(wr_en), 0);
    tick();
    chk("t1_wr_en_t2", 32'(wr_en), 1);
    chk("t1_grant_t2", 32'(grant), 32'b0100);
    tick();
    chk("t1_pending_after", 32'(pending), 0);
    chk("t1_wr_en_gap", 32'(wr_en), 0);
    chk("t1_busy_gap", 32'(busy), 1);
    tick();
    chk("t1_busy_idle", 32'(busy), 0);
    wait_drain(20);

    // All four strobe together: order 0..3, three cycles apart.
    do_reset();
    wr_ready = 1'b1;
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 6'(6'h10 + i), 8'(8'h11 * (i + 1)));
      push(i, 6'(6'h10 + i), 8'(8'h11 * (i + 1)), t + 2 + 3 * i);
    end
    tick();
    req_strobe = '0;
    wait_drain(40);
    chk("t2_overrun", 32'(overrun), 0);

    // Round-robin fairness with re-strobing after each accept.
    do_reset();
    wr_ready = 1'b1;
    set_req(0, 6'h01, 8'hA0);
    set_req(1, 6'h02, 8'hB0);
    push(0, 6'h01, 8'hA0, -1);
    push(1, 6'h02, 8'hB0, -1);
    tick();
    req_strobe = '0;
    for (int n = 1; n <= 4; n++) begin
      wait_accept(g, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
      set_req(g, 6'(g + 1), 8'((g == 0 ? 8'hA0 : 8'hB0) + n));
      push(g, 6'(g + 1), 8'((g == 0 ? 8'hA0 : 8'hB0) + n), -1);
      tick();
      req_strobe = '0;
    end
    wait_drain(40);
    chk("t3_overrun", 32'(overrun), 0);

    // Overrun while stalled; set beats clear; sticky until cleared.
    do_reset();
    set_req(1, 6'h21, 8'h55);
    push(1, 6'h21, 8'h55, -1);
    tick();
    set_req(1, 6'h22, 8'h66);
    tick();
    req_strobe = '0;
    chk("t4_overrun_set", 32'(overrun), 32'b0010);
    chk("t4_pending", 32'(pending), 32'b0010);
    chk("t4_wr_data_kept", 32'(wr_data), 32'h55);
    set_req(1, 6'h23, 8'h77);
    overrun_clr = 1'b1;
    tick();
    req_strobe  = '0;
    overrun_clr = 1'b0;
    chk("t4_set_wins", 32'(overrun), 32'b0010);
    wr_ready = 1'b1;
    wait_drain(20);
    chk("t4_overrun_sticky", 32'(overrun), 32'b0010);
    chk("t4_pending_done", 32'(pending), 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 0);

    // Strobe in the same cycle the pending word is accepted.
    do_reset();
    t = cyc;
    set_req(3, 6'h03, 8'h31);
    push(3, 6'h03, 8'h31, t + 3);
    tick();
    req_strobe = '0;
    tick();
    tick();
    wr_ready = 1'b1;
    set_req(3, 6'h04, 8'h32);
    push(3, 6'h04, 8'h32, t + 6);
    tick();
    req_strobe = '0;
    chk("t5_pending_kept", 32'(pending), 32'b1000);
    chk("t5_no_overrun", 32'(overrun), 0);
    chk("t5_wr_en_gap", 32'(wr_en), 0);
    wait_drain(20);

    // Asynchronous reset in the middle of a stalled write.
    do_reset();
    set_req(2, 6'h2A, 8'hAA);
    tick();
    req_strobe = '0;
    tick();
    chk("t6_issue", 32'(wr_en), 1);
    set_req(3, 6'h3B, 8'hBB);
    tick();
    req_strobe = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_abort_wr_en", 32'(wr_en), 0);
    chk("t6_abort_pending", 32'(pending), 0);
    chk("t6_abort_grant", 32'(grant), 0);
    do_reset();
    wr_ready = 1'b1;
    t = cyc;
    set_req(3, 6'h3C, 8'hCC);
    set_req(0, 6'h0D, 8'hDD);
    push(0, 6'h0D, 8'hDD, t + 2);
    push(3, 6'h3C, 8'hCC, t + 5);
    tick();
    req_strobe = '0;
    wait_drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
